sort4_ctrl: RTL and testbench

//  Sorts four unsigned N-bit operands into ascending order.

---
 rtl/sort4_ctrl_pkg.sv | 41 ++++
 rtl/sort4_ctrl_alu.sv | 52 +++++
 rtl/sort4_ctrl.sv | 135 +++++++++++++
 tb/tb_sort4_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sort4_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sort4_ctrl_pkg
// Shared definitions for the four-operand sorter and its ALU:
//   - ALU opcode constants (only SUB is used by the sorter)
//   - sorter FSM state encoding
//   - the fixed bubble-sort pair schedule, indexed by the pair counter k
// ---------------------------------------------------------------------------
package sort4_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } sort_state_t;

  // Index of the final compare in the schedule; after it the sort is complete.
  localparam logic [2:0] LAST_PAIR = 3'd5;

  // Schedule table: k -> lower index i of the compared pair (i, i+1).
  // Three passes of shrinking length: (0,1)(1,2)(2,3) (0,1)(1,2) (0,1).
  function automatic logic [1:0] pair_index(input logic [2:0] k);
    logic [1:0] idx;
    case (k)
      3'd0:    idx = 2'd0;
      3'd1:    idx = 2'd1;
      3'd2:    idx = 2'd2;
      3'd3:    idx = 2'd0;
      3'd4:    idx = 2'd1;
      3'd5:    idx = 2'd0;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sort4_ctrl_alu.sv
// ---------------------------------------------------------------------------
// sort4_ctrl_alu
// The lab's small combinational ALU, parameterised on operand width.
// Ports:
//   a, b  in  N  operands
//   m     in  3  opcode (OP_ADD / OP_SUB / OP_AND / OP_OR / OP_XOR)
//   y     out N  result
//   cf    out 1  carry out for ADD, borrow (a < b unsigned) for SUB
//   zf    out 1  result is zero
//   of    out 1  signed overflow for ADD / SUB, 0 otherwise
// ---------------------------------------------------------------------------
module sort4_ctrl_alu
  import sort4_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   m,
  output logic [N-1:0] y,
  output logic         cf,
  output logic         zf,
  output logic         of
);

  logic [N:0] wide;

  // One extra result bit carries the carry/borrow; in SUB mode the top bit
  // of {0,a}-{0,b} is set exactly when a < b as unsigned numbers.
  always_comb begin
    wide = '0;
    of   = 1'b0;
    case (m)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        of   = (a[N-1] == b[N-1]) && (wide[N-1] != a[N-1]);
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        of   = (a[N-1] != b[N-1]) && (wide[N-1] != a[N-1]);
      end
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      default: wide = '0;
    endcase
    y  = wide[N-1:0];
    cf = wide[N];
    zf = (wide[N-1:0] == '0);
  end

endmodule

// File: rtl/sort4_ctrl.sv
// ---------------------------------------------------------------------------
// sort4_ctrl
// Sorts four unsigned N-bit operands into ascending order with a fixed
// six-compare bubble-sort schedule, using one shared ALU in SUB mode as the
// only comparator (its borrow flag says "upper < lower, swap").
// Ports:
//   clk       in   1  clock, rising edge
//   rst       in   1  synchronous active-high reset, aborts any sort
//   start     in   1  load x0..x3 and sort; accepted in IDLE or DONE only
//   x0..x3    in   N  unsorted operands
//   s0..s3    out  N  working/result registers, s0 smallest when done
//   busy      out  1  high during the six compare cycles
//   done      out  1  one-cycle pulse when s0..s3 hold the sorted result
//   swap_cnt  out  3  swaps performed by the last sort (inversion count)
// ---------------------------------------------------------------------------
module sort4_ctrl
  import sort4_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x0,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] x2,
  input  logic [N-1:0] x3,
  output logic [N-1:0] s0,
  output logic [N-1:0] s1,
  output logic [N-1:0] s2,
  output logic [N-1:0] s3,
  output logic         busy,
  output logic         done,
  output logic [2:0]   swap_cnt
);

  sort_state_t  state;
  sort_state_t  state_next;
  logic [2:0]   k;
  logic [N-1:0] s_reg [4];

  logic [1:0]   lo_idx;
  logic [1:0]   hi_idx;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_cf;
  logic [N-1:0] unused_alu_y;
  logic         unused_alu_zf;
  logic         unused_alu_of;

  // Operand muxes: the pair counter picks (i, i+1) from the schedule table,
  // and the ALU computes s[i+1] - s[i]; a borrow means the pair is out of
  // order. Equal values produce no borrow, which keeps the sort stable.
  always_comb begin
    lo_idx = pair_index(k);
    hi_idx = lo_idx + 2'd1;
    alu_a  = s_reg[hi_idx];
    alu_b  = s_reg[lo_idx];
  end

  sort4_ctrl_alu #(.N(N)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .m  (OP_SUB),
    .y  (unused_alu_y),
    .cf (alu_cf),
    .zf (unused_alu_zf),
    .of (unused_alu_of)
  );

  // State register and datapath. A start in IDLE or DONE loads fresh
  // operands; in CMP every cycle performs one scheduled compare and a swap
  // when the ALU reports a borrow. Starts arriving during CMP are ignored,
  // so the operands of a running sort can never be disturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      swap_cnt <= '0;
      for (int i = 0; i < 4; i++) s_reg[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            s_reg[0] <= x0;
            s_reg[1] <= x1;
            s_reg[2] <= x2;
            s_reg[3] <= x3;
            swap_cnt <= '0;
            k        <= '0;
          end
        end
        CMP: begin
          if (alu_cf) begin
            s_reg[lo_idx] <= alu_a;
            s_reg[hi_idx] <= alu_b;
            swap_cnt      <= swap_cnt + 3'd1;
          end
          k <= k + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and status outputs. The schedule length is fixed, so the
  // data pattern never affects timing: six CMP cycles, then one DONE cycle.
  // DONE behaves like IDLE towards start, giving back-to-back sorts.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CMP;
      end
      CMP: begin
        busy = 1'b1;
        if (k == LAST_PAIR) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? CMP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign s0 = s_reg[0];
  assign s1 = s_reg[1];
  assign s2 = s_reg[2];
  assign s3 = s_reg[3];

endmodule

// File: tb/tb_sort4_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sort4_ctrl
// Self-checking bench for sort4_ctrl (N=4). A behavioural model tracks how
// many cycles have passed since the last accepted start and what the sorted
// result and inversion count of the loaded operands must be; a compare
// process checks busy/done every cycle and the result whenever it is final.
// Directed sequences add literal expectations, then random traffic follows.
// ---------------------------------------------------------------------------
module tb_sort4_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
  logic [3:0] s0, s1, s2, s3;
  logic       busy, done;
  logic [2:0] swap_cnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state: phase 0 = no sort in flight, 1..6 = compare cycles,
  // 7 = done cycle. m_res = {swaps, s3, s2, s1, s0} of the current sort.
  int          m_phase = 0;
  logic [18:0] m_res = '0;
  int          m_done_cnt = 0;
  int          dut_done_cnt = 0;

  sort4_ctrl #(.N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x0       (x0),
    .x1       (x1),
    .x2       (x2),
    .x3       (x3),
    .s0       (s0),
    .s1       (s1),
    .s2       (s2),
    .s3       (s3),
    .busy     (busy),
    .done     (done),
    .swap_cnt (swap_cnt)
  );

  always #5 clk = ~clk;

  // Reference sort: count inversions over all pairs, then insertion sort.
  function automatic logic [18:0] model_sort(input logic [3:0] a0, a1, a2, a3);
    logic [3:0] v [4];
    logic [3:0] t;
    int inv;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    inv = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[i] > v[j]) inv++;
    for (int i = 1; i < 4; i++)
      for (int j = i; j > 0; j--)
        if (v[j-1] > v[j]) begin
          t = v[j]; v[j] = v[j-1]; v[j-1] = t;
        end
    return {3'(inv), v[3], v[2], v[1], v[0]};
  endfunction

  task automatic compare_value(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, advanced on the same edges the DUT samples.
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_res   <= '0;
    end else if ((m_phase == 0 || m_phase == 7) && start) begin
      m_phase <= 1;
      m_res   <= model_sort(x0, x1, x2, x3);
    end else if (m_phase >= 1 && m_phase <= 6) begin
      m_phase <= m_phase + 1;
      if (m_phase == 6) m_done_cnt <= m_done_cnt + 1;
    end else begin
      m_phase <= 0;
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      compare_value("busy", busy, (m_phase >= 1 && m_phase <= 6));
      compare_value("done", done, (m_phase == 7));
      if (m_phase == 0 || m_phase == 7) begin
        compare_value("result", {swap_cnt, s3, s2, s1, s0}, m_res);
      end
      if (done) dut_done_cnt++;
    end
  end

  // Drive operands with start for one cycle; returns on the falling edge
  // of the first compare cycle.
  task automatic applyStimulus(input logic [3:0] a0, a1, a2, a3);
    @(negedge clk);
    x0 = a0; x1 = a1; x2 = a2; x3 = a3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait pre_cycles falling edges expecting no done, then expect the done
  // pulse with the given literal result, then expect done to have dropped.
  task automatic checkOutput(input int pre_cycles, input logic [3:0] e0, e1, e2, e3,
                             input logic [2:0] es);
    repeat (pre_cycles) begin
      @(negedge clk);
      compare_value("done_early", done, 1'b0);
    end
    @(negedge clk);
    compare_value("done_pulse", done, 1'b1);
    compare_value("sorted", {s3, s2, s1, s0}, {e3, e2, e1, e0});
    compare_value("swap_cnt", swap_cnt, es);
    @(negedge clk);
    compare_value("done_single", done, 1'b0);
  endtask

  logic [18:0] pin;

  initial begin
    // Model pins against hand-computed results.
    pin = model_sort(4'h3, 4'h1, 4'h2, 4'h0);
    compare_value("model_pin_a", pin, {3'd5, 4'h3, 4'h2, 4'h1, 4'h0});
    pin = model_sort(4'hF, 4'h0, 4'h8, 4'h7);
    compare_value("model_pin_b", pin, {3'd4, 4'hF, 4'h8, 4'h7, 4'h0});
    pin = model_sort(4'h5, 4'h5, 4'h2, 4'h5);
    compare_value("model_pin_c", pin, {3'd2, 4'h5, 4'h5, 4'h5, 4'h2});

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_value("reset_s", {s3, s2, s1, s0}, 16'h0000);
    compare_value("reset_busy", busy, 1'b0);
    compare_value("reset_done", done, 1'b0);
    compare_value("reset_swap", swap_cnt, 3'd0);
    check_en = 1'b1;

    // Basic, sorted, reversed, unsigned extremes, duplicates.
    applyStimulus(4'h3, 4'h1, 4'h2, 4'h0);
    compare_value("busy_first", busy, 1'b1);
    checkOutput(5, 4'h0, 4'h1, 4'h2, 4'h3, 3'd5);
    applyStimulus(4'h1, 4'h2, 4'h3, 4'h4);
    checkOutput(5, 4'h1, 4'h2, 4'h3, 4'h4, 3'd0);
    applyStimulus(4'hF, 4'hA, 4'h5, 4'h0);
    checkOutput(5, 4'h0, 4'h5, 4'hA, 4'hF, 3'd6);
    applyStimulus(4'hF, 4'h0, 4'h8, 4'h7);
    checkOutput(5, 4'h0, 4'h7, 4'h8, 4'hF, 3'd4);
    applyStimulus(4'h5, 4'h5, 4'h2, 4'h5);
    checkOutput(5, 4'h2, 4'h5, 4'h5, 4'h5, 3'd2);
    applyStimulus(4'h7, 4'h7, 4'h7, 4'h7);
    checkOutput(5, 4'h7, 4'h7, 4'h7, 4'h7, 3'd0);

    // start during CMP with different operands must be ignored.
    applyStimulus(4'h3, 4'h1, 4'h2, 4'h0);
    @(negedge clk);
    x0 = 4'h9; x1 = 4'h8; x2 = 4'hE; x3 = 4'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput(3, 4'h0, 4'h1, 4'h2, 4'h3, 3'd5);

    // Reset in the third compare cycle aborts with no done pulse.
    applyStimulus(4'hF, 4'hA, 4'h5, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compare_value("abort_s", {s3, s2, s1, s0}, 16'h0000);
    compare_value("abort_busy", busy, 1'b0);
    repeat (10) begin
      @(negedge clk);
      compare_value("abort_no_done", done, 1'b0);
    end

    // start held through DONE: second sort begins straight away.
    applyStimulus(4'h3, 4'h1, 4'h2, 4'h0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    x0 = 4'h2; x1 = 4'h1; x2 = 4'h0; x3 = 4'h3;
    start = 1'b1;
    @(negedge clk);
    compare_value("b2b_done1", done, 1'b1);
    compare_value("b2b_sorted1", {s3, s2, s1, s0}, {4'h3, 4'h2, 4'h1, 4'h0});
    compare_value("b2b_swap1", swap_cnt, 3'd5);
    @(negedge clk);
    start = 1'b0;
    compare_value("b2b_busy2", busy, 1'b1);
    compare_value("b2b_nodone", done, 1'b0);
    checkOutput(5, 4'h0, 4'h1, 4'h2, 4'h3, 3'd3);

    compare_value("done_count_directed", dut_done_cnt, 32'd9);

    // Random traffic: operands, start level and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      x0 = 4'($urandom_range(0, 15));
      x1 = 4'($urandom_range(0, 15));
      x2 = 4'($urandom_range(0, 15));
      x3 = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    compare_value("done_count_total", dut_done_cnt, m_done_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
